// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for the AXI4-lite byte-serial multiplier slave.
//   w_state_t : write-channel FSM states
//   r_state_t : read-channel FSM states
//   NB        : bytes per operand for the default 32-bit / 8-bit configuration
//   RESP_OK / RESP_ERR : 1-bit response encodings used on bresp / rresp
package axi4_lite_pkg;

   localparam int SZ_DEF  = 32;
   localparam int DSZ_DEF = 8;
   localparam int NB      = SZ_DEF / DSZ_DEF;

   localparam logic RESP_OK  = 1'b1;
   localparam logic RESP_ERR = 1'b0;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA} r_state_t;

endpackage

// File: rtl/axi4_lite_mult_slave_mult_core.sv
// mult_core: registered unsigned SZ x SZ multiplier, one cycle of latency.
// Ports:
//   _rst  in  async active-low reset (clears the product)
//   clk   in  clock
//   a, b  in  SZ-bit unsigned operands
//   p     out 2*SZ-bit registered product a*b, never truncated
module mult_core #(
   parameter int SZ = 32
) (
   input  logic            _rst,
   input  logic            clk,
   input  logic [SZ-1:0]   a,
   input  logic [SZ-1:0]   b,
   output logic [2*SZ-1:0] p
);

   // Zero-extend both operands so the multiply is evaluated at full 2*SZ width.
   always_ff @(posedge clk or negedge _rst) begin
      if (!_rst) p <= '0;
      else       p <= {{SZ{1'b0}}, a} * {{SZ{1'b0}}, b};
   end

endmodule

// File: rtl/axi4_lite_mult_slave.sv
// axi4_lite_mult_slave: AXI4-lite slave for the byte-serial multiplier link.
// Byte writes to addr 0..NB-1 / NB..2*NB-1 assemble operands A / B; a registered
// multiplier forms A*B; byte reads of addr 0..2*NB-1 return the product, low byte
// first. Reading byte 0 captures the product into a snapshot so the remaining
// bytes stay coherent even if the operands are rewritten mid-read.
// Write and read channels are fully independent.
// Configuration macro: ADDR_CHECK_EN
//   defined   : address >= 2*NB answers with response 0, no write, read data 0
//   undefined : address is masked to addr & (2*NB-1), responses always 1
// Ports:
//   _rst, clk                       async active-low reset, clock
//   awaddr/awvalid/awready          write address channel
//   wdata/wvalid/wready             write data channel (one byte)
//   bresp/bvalid/bready             write response channel (1 => ok)
//   araddr/arvalid/arready          read address channel
//   rdata/rvalid/rready/rresp       read data channel (one byte, 1 => ok)
//   op_a, op_b                      operand registers
//   prod                            registered product op_a*op_b
//
// state  | meaning
// W_IDLE | waiting for a write address (awready=1)
// W_DATA | address latched, waiting for the data byte (wready=1)
// W_RESP | write done, holding bvalid until bready
// R_IDLE | waiting for a read address (arready=1)
// R_DATA | rdata loaded, holding rvalid until rready
module axi4_lite_mult_slave
   import axi4_lite_pkg::*;
#(
   parameter int SZ  = 32,
   parameter int ASZ = 4,
   parameter int DSZ = 8
) (
   input  logic            _rst,
   input  logic            clk,
   input  logic [ASZ-1:0]  awaddr,
   input  logic            awvalid,
   output logic            awready,
   input  logic [DSZ-1:0]  wdata,
   input  logic            wvalid,
   output logic            wready,
   output logic            bresp,
   output logic            bvalid,
   input  logic            bready,
   input  logic [ASZ-1:0]  araddr,
   input  logic            arvalid,
   output logic            arready,
   output logic [DSZ-1:0]  rdata,
   output logic            rvalid,
   input  logic            rready,
   output logic            rresp,
   output logic [SZ-1:0]   op_a,
   output logic [SZ-1:0]   op_b,
   output logic [2*SZ-1:0] prod
);

   localparam int NBM = SZ / DSZ;
   localparam int IW  = $clog2(2 * NBM);

   w_state_t w_state, w_next;
   r_state_t r_state, r_next;

   logic [ASZ-1:0]  aw_q;
   logic [IW-1:0]   w_idx, r_idx;
   logic            w_ok, r_ok;
   logic [2*SZ-1:0] snapshot;

`ifdef ADDR_CHECK_EN
   localparam logic [ASZ-1:0] ALIM = ASZ'(2 * NBM);
   assign w_ok  = (aw_q < ALIM);
   assign r_ok  = (araddr < ALIM);
   assign w_idx = aw_q[IW-1:0];
   assign r_idx = araddr[IW-1:0];
`else
   localparam logic [ASZ-1:0] AMASK = ASZ'(2 * NBM - 1);
   assign w_ok  = RESP_OK;
   assign r_ok  = RESP_OK;
   assign w_idx = IW'(aw_q & AMASK);
   assign r_idx = IW'(araddr & AMASK);
`endif

   mult_core #(.SZ(SZ)) u_mult (
      ._rst (_rst),
      .clk  (clk),
      .a    (op_a),
      .b    (op_b),
      .p    (prod)
   );

   always_ff @(posedge clk or negedge _rst) begin
      if (!_rst) begin
         w_state <= W_IDLE;
         r_state <= R_IDLE;
      end else begin
         w_state <= w_next;
         r_state <= r_next;
      end
   end

   always_comb begin
      w_next  = w_state;
      awready = 1'b0;
      wready  = 1'b0;
      bvalid  = 1'b0;
      case (w_state)
         W_IDLE: begin
            awready = 1'b1;
            if (awvalid) w_next = W_DATA;
         end
         W_DATA: begin
            wready = 1'b1;
            if (wvalid) w_next = W_RESP;
         end
         W_RESP: begin
            bvalid = 1'b1;
            if (bready) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   always_comb begin
      r_next  = r_state;
      arready = 1'b0;
      rvalid  = 1'b0;
      case (r_state)
         R_IDLE: begin
            arready = 1'b1;
            if (arvalid) r_next = R_DATA;
         end
         R_DATA: begin
            rvalid = 1'b1;
            if (rready) r_next = R_IDLE;
         end
         default: r_next = R_IDLE;
      endcase
   end

   // Write datapath: the top index bit selects operand B, the rest pick the byte.
   always_ff @(posedge clk or negedge _rst) begin
      if (!_rst) begin
         aw_q  <= '0;
         op_a  <= '0;
         op_b  <= '0;
         bresp <= RESP_ERR;
      end else begin
         if (awvalid && awready) aw_q <= awaddr;
         if (wvalid && wready) begin
            bresp <= w_ok;
            if (w_ok) begin
               if (w_idx[IW-1]) op_b[w_idx[IW-2:0]*DSZ +: DSZ] <= wdata;
               else             op_a[w_idx[IW-2:0]*DSZ +: DSZ] <= wdata;
            end
         end
      end
   end

   // Read datapath: byte 0 re-captures the product, later bytes come from the snapshot.
   always_ff @(posedge clk or negedge _rst) begin
      if (!_rst) begin
         snapshot <= '0;
         rdata    <= '0;
         rresp    <= RESP_ERR;
      end else if (arvalid && arready) begin
         rresp <= r_ok;
         if (!r_ok) begin
            rdata <= '0;
         end else if (r_idx == '0) begin
            snapshot <= prod;
            rdata    <= prod[DSZ-1:0];
         end else begin
            rdata <= snapshot[r_idx*DSZ +: DSZ];
         end
      end
   end

endmodule

// File: tb/tb_axi4_lite_mult_slave.sv
module tb_axi4_lite_mult_slave;

   localparam int TMO = 50;

   logic        rst_n, clk;
   logic [3:0]  awaddr, araddr;
   logic        awvalid, awready, wvalid, wready, bresp, bvalid, bready;
   logic        arvalid, arready, rvalid, rready, rresp;
   logic [7:0]  wdata, rdata;
   logic [31:0] op_a, op_b;
   logic [63:0] prod;

   int checks = 0;
   int errors = 0;

   logic [31:0] model_a = '0;
   logic [31:0] model_b = '0;
   logic [63:0] model_snap = '0;

   logic        wq[$];
   logic [8:0]  rq[$];

   axi4_lite_mult_slave dut (
      ._rst    (rst_n),
      .clk     (clk),
      .awaddr  (awaddr),
      .awvalid (awvalid),
      .awready (awready),
      .wdata   (wdata),
      .wvalid  (wvalid),
      .wready  (wready),
      .bresp   (bresp),
      .bvalid  (bvalid),
      .bready  (bready),
      .araddr  (araddr),
      .arvalid (arvalid),
      .arready (arready),
      .rdata   (rdata),
      .rvalid  (rvalid),
      .rready  (rready),
      .rresp   (rresp),
      .op_a    (op_a),
      .op_b    (op_b),
      .prod    (prod)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int map_idx(input logic [3:0] a, output bit oob);
`ifdef ADDR_CHECK_EN
      oob = (a >= 4'd8);
      return int'(a[2:0]);
`else
      oob = 1'b0;
      return int'(a & 4'd7);
`endif
   endfunction

   task automatic do_write(input logic [3:0] a, input logic [7:0] d, input int hold);
      bit   oob;
      int   i, n;
      logic exp;
      i = map_idx(a, oob);
      wq.push_back(!oob);
      if (!oob) begin
         if (i < 4) model_a[8*i +: 8] = d;
         else       model_b[8*(i-4) +: 8] = d;
      end
      @(negedge clk);
      awaddr = a; awvalid = 1'b1;
      n = 0;
      while (!awready && n < TMO) begin @(negedge clk); n++; end
      if (n == TMO) check("aw_timeout", 64'(awready), 64'd1);
      @(negedge clk);
      awvalid = 1'b0; wdata = d; wvalid = 1'b1;
      n = 0;
      while (!wready && n < TMO) begin @(negedge clk); n++; end
      if (n == TMO) check("w_timeout", 64'(wready), 64'd1);
      @(negedge clk);
      wvalid = 1'b0;
      n = 0;
      while (!bvalid && n < TMO) begin @(negedge clk); n++; end
      if (n == TMO) check("b_timeout", 64'(bvalid), 64'd1);
      exp = wq.pop_front();
      check("bresp", 64'(bresp), 64'(exp));
      for (int h = 0; h < hold; h++) begin
         awaddr = 4'd5; awvalid = 1'b1;
         @(negedge clk);
         check("bvalid_hold", 64'(bvalid), 64'd1);
         check("bresp_hold", 64'(bresp), 64'(exp));
         check("awready_hold", 64'(awready), 64'd0);
      end
      awvalid = 1'b0;
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      check("bvalid_clr", 64'(bvalid), 64'd0);
   endtask

   task automatic do_read(input logic [3:0] a, input int hold, output logic [7:0] got);
      bit         oob;
      int         i, n;
      logic [8:0] exp;
      i = map_idx(a, oob);
      if (oob) begin
         exp = {1'b0, 8'h00};
      end else begin
         if (i == 0) model_snap = 64'(model_a) * 64'(model_b);
         exp = {1'b1, model_snap[8*i +: 8]};
      end
      rq.push_back(exp);
      @(negedge clk);
      araddr = a; arvalid = 1'b1;
      n = 0;
      while (!arready && n < TMO) begin @(negedge clk); n++; end
      if (n == TMO) check("ar_timeout", 64'(arready), 64'd1);
      @(negedge clk);
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < TMO) begin @(negedge clk); n++; end
      if (n == TMO) check("r_timeout", 64'(rvalid), 64'd1);
      exp = rq.pop_front();
      check("rresp", 64'(rresp), 64'(exp[8]));
      check("rdata", 64'(rdata), 64'(exp[7:0]));
      got = rdata;
      for (int h = 0; h < hold; h++) begin
         araddr = 4'd2; arvalid = 1'b1;
         @(negedge clk);
         check("rvalid_hold", 64'(rvalid), 64'd1);
         check("rdata_hold", 64'(rdata), 64'(exp[7:0]));
         check("arready_hold", 64'(arready), 64'd0);
      end
      arvalid = 1'b0;
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      check("rvalid_clr", 64'(rvalid), 64'd0);
   endtask

   task automatic write_ops(input logic [31:0] a, input logic [31:0] b);
      for (int i = 0; i < 4; i++) do_write(4'(i), a[8*i +: 8], 0);
      for (int i = 0; i < 4; i++) do_write(4'(i + 4), b[8*i +: 8], 0);
   endtask

   task automatic read_prod(output logic [63:0] v);
      logic [7:0] g;
      v = '0;
      for (int i = 0; i < 8; i++) begin
         do_read(4'(i), 0, g);
         v[8*i +: 8] = g;
      end
   endtask

   initial begin
      logic [63:0] v;
      logic [7:0]  g;
      logic [31:0] ra, rb;

      rst_n = 1'b0;
      awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arvalid = 1'b0; rready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      check("rst_awready", 64'(awready), 64'd1);
      check("rst_arready", 64'(arready), 64'd1);
      check("rst_wready", 64'(wready), 64'd0);
      check("rst_bvalid", 64'(bvalid), 64'd0);
      check("rst_rvalid", 64'(rvalid), 64'd0);
      check("rst_bresp", 64'(bresp), 64'd0);
      check("rst_rresp", 64'(rresp), 64'd0);
      check("rst_rdata", 64'(rdata), 64'd0);
      check("rst_op_a", 64'(op_a), 64'd0);
      check("rst_prod", prod, 64'd0);

      // Operand assembly and product
      write_ops(32'h12345678, 32'h00000002);
      check("op_a", 64'(op_a), 64'h12345678);
      check("op_b", 64'(op_b), 64'h2);
      check("prod", prod, 64'h2468ACF0);

      // Snapshot coherence with op_b rewritten while byte 3 is being read
      v = '0;
      for (int i = 0; i < 3; i++) begin
         do_read(4'(i), 0, g);
         v[8*i +: 8] = g;
      end
      fork
         do_write(4'd4, 8'h03, 0);
         do_read(4'd3, 0, g);
      join
      v[31:24] = g;
      for (int i = 4; i < 8; i++) begin
         do_read(4'(i), 0, g);
         v[8*i +: 8] = g;
      end
      check("snap_read", v, 64'h2468ACF0);
      check("op_b_new", 64'(op_b), 64'h3);
      check("prod_new", prod, 64'h369D0368);

      // Backpressure on both response channels
      fork
         do_write(4'd4, 8'h02, 5);
         do_read(4'd1, 5, g);
      join

      // Full-width product
      write_ops(32'hFFFFFFFF, 32'hFFFFFFFF);
      read_prod(v);
      check("ff_read", v, 64'hFFFFFFFE00000001);
      check("ff_prod", prod, 64'hFFFFFFFE00000001);

      // Out-of-range addresses
      do_write(4'd9, 8'hAB, 0);
      do_read(4'd12, 0, g);
`ifdef ADDR_CHECK_EN
      check("oob_op_a", 64'(op_a), 64'hFFFFFFFF);
      check("oob_rdata", 64'(g), 64'h00);
`else
      check("wrap_op_a", 64'(op_a), 64'hFFFFABFF);
      check("wrap_rdata", 64'(g), 64'hFE);
`endif

      // Random operand sweep
      for (int t = 0; t < 4; t++) begin
         ra = $urandom;
         rb = $urandom;
         write_ops(ra, rb);
         read_prod(v);
         check("sweep", v, 64'(ra) * 64'(rb));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: observed timeout expected completion");
      $fatal(1, "global timeout");
   end

endmodule
